// File: rtl/chunked_adder_pkg.sv
// Shared types and helpers for the chunked add/subtract unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package chunked_adder_pkg;

    // Controller states; the encoding is fixed so debug probes can decode it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Chunk counter width: ceil(log2(n)), never below one bit so N=1 still
    // has a real register.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunked_adder_slice.sv
// CHUNK-bit combinational ripple adder built from full-adder cells.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows the inputs.
module chunk_slice
    import chunked_adder_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    // Internal ripple carries; c[i] is the carry into bit i.
    logic [CHUNK:0] c;

    // Ripple the carry through CHUNK full-adder cells, LSB first.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[CHUNK];
    // Carry into the slice MSB; on the last slice this is the carry into the
    // word's sign bit, which the overflow flag needs.
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock through one ripple slice.
// Latency: start accepted at edge k -> done pulses in the cycle after edge k+N (N = WIDTH/CHUNK).
// Backpressure: start is only taken in IDLE or DONE; start while busy is ignored.
module chunked_adder
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             co,
    output logic             overflow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // A width that is not a whole number of chunks would leave bits unprocessed.
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("chunked_adder: WIDTH must be a multiple of CHUNK");
    end

    // Controller and datapath state.
    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] z_q,     z_d;
    logic             co_q,    co_d;
    logic             ovf_q,   ovf_d;

    // Slice interface.
    logic [31:0]      base;
    logic [CHUNK-1:0] sl_a;
    logic [CHUNK-1:0] sl_b;
    logic [CHUNK-1:0] sl_s;
    logic             sl_cout;
    logic             sl_cmsb;

    // Select the operand chunk addressed by the counter for the shared slice.
    always_comb begin
        base = 32'(cnt_q) * 32'(CHUNK);
        sl_a = a_q[base +: CHUNK];
        sl_b = b_q[base +: CHUNK];
    end

    chunk_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .cin   (carry_q),
        .s     (sl_s),
        .cout  (sl_cout),
        .c_msb (sl_cmsb)
    );

    // Next-state logic: accept operands, step one chunk per RUN cycle, and
    // publish the result only on the final chunk.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        z_d     = z_q;
        co_d    = co_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Subtraction is x + ~y + ~borrow, so the slice only ever adds.
                    a_d     = x;
                    b_d     = sub ? ~y : y;
                    carry_d = sub ? ~ci : ci;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                acc_d[base +: CHUNK] = sl_s;
                carry_d              = sl_cout;
                if (cnt_q == LAST) begin
                    // Counter parks at zero so it never addresses past the word.
                    cnt_d   = '0;
                    z_d     = acc_d;
                    co_d    = sl_cout;
                    ovf_d   = sl_cmsb ^ sl_cout;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            z_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            z_q     <= z_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign z        = z_q;
    assign co       = co_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Scoreboard bench for chunked_adder: three builds (16/4, 16/16, 17/1) driven one at a time.
// Driver pushes model results into a queue; per-build monitors pop and compare on done.
// Monitors also check busy length and that outputs hold between completions.
module tb_chunked_adder;

    typedef struct {
        int          d;
        logic [16:0] z;
        logic        co;
        logic        ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start_i [3];
    logic        sub_i   [3];
    logic [16:0] x_i     [3];
    logic [16:0] y_i     [3];
    logic        ci_i    [3];
    logic        busy_o  [3];
    logic        done_o  [3];
    logic        co_o    [3];
    logic        ov_o    [3];
    logic [15:0] z0;
    logic [15:0] z1;
    logic [16:0] z2;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    chunked_adder #(.WIDTH(16), .CHUNK(4)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_i[0]), .sub(sub_i[0]),
        .x(x_i[0][15:0]), .y(y_i[0][15:0]), .ci(ci_i[0]),
        .busy(busy_o[0]), .done(done_o[0]), .z(z0), .co(co_o[0]), .overflow(ov_o[0]));

    chunked_adder #(.WIDTH(16), .CHUNK(16)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_i[1]), .sub(sub_i[1]),
        .x(x_i[1][15:0]), .y(y_i[1][15:0]), .ci(ci_i[1]),
        .busy(busy_o[1]), .done(done_o[1]), .z(z1), .co(co_o[1]), .overflow(ov_o[1]));

    chunked_adder #(.WIDTH(17), .CHUNK(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_i[2]), .sub(sub_i[2]),
        .x(x_i[2]), .y(y_i[2]), .ci(ci_i[2]),
        .busy(busy_o[2]), .done(done_o[2]), .z(z2), .co(co_o[2]), .overflow(ov_o[2]));

    function automatic int wid(input int d);
        return (d == 2) ? 17 : 16;
    endfunction

    function automatic int nn(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 1 : 17);
    endfunction

    function automatic logic [16:0] get_z(input int d);
        if (d == 0) return {1'b0, z0};
        if (d == 1) return {1'b0, z1};
        return z2;
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input int d, input bit s, input logic [16:0] a,
                                   input logic [16:0] b, input bit c);
        exp_t   e;
        longint m, xa, ya, u, sx, sy, r, cc;
        m  = longint'(1) << wid(d);
        xa = longint'(a) & (m - 1);
        ya = longint'(b) & (m - 1);
        cc = c ? 1 : 0;
        u  = s ? (xa - ya - cc) : (xa + ya + cc);
        sx = (xa >= m / 2) ? xa - m : xa;
        sy = (ya >= m / 2) ? ya - m : ya;
        r  = s ? (sx - sy - cc) : (sx + sy + cc);
        e.d  = d;
        e.z  = 17'(u & (m - 1));
        e.co = s ? (u >= 0) : (u >= m);
        e.ov = (r >= m / 2) || (r < -(m / 2));
        return e;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // One monitor per build: busy length, result on done, hold otherwise.
    for (genvar gd = 0; gd < 3; gd++) begin : g_mon
        int          bcnt = 0;
        logic [16:0] last_z = '0;
        logic        last_co = 1'b0;
        logic        last_ov = 1'b0;
        exp_t        e;
        always begin
            @(posedge clk);
            #2;
            if (rst) begin
                bcnt    = 0;
                last_z  = '0;
                last_co = 1'b0;
                last_ov = 1'b0;
            end else begin
                if (busy_o[gd]) bcnt++;
                if (done_o[gd]) begin
                    check($sformatf("busy_cycles[%0d]", gd), bcnt, nn(gd));
                    bcnt = 0;
                    if (exp_q.size() == 0 || exp_q[0].d != gd) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL spurious_done[%0d]: done seen, no result expected", gd);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("z[%0d]", gd),  32'(get_z(gd)), 32'(e.z));
                        check($sformatf("co[%0d]", gd), 32'(co_o[gd]),  32'(e.co));
                        check($sformatf("ov[%0d]", gd), 32'(ov_o[gd]),  32'(e.ov));
                        last_z  = e.z;
                        last_co = e.co;
                        last_ov = e.ov;
                    end
                end else begin
                    check($sformatf("z_hold[%0d]", gd),
                          {12'd0, last_co, last_ov, 1'b0, get_z(gd)},
                          {12'd0, co_o[gd], ov_o[gd], 1'b0, last_z});
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue one operation at a negedge with the build not busy; returns at
    // the negedge of its done cycle so a following call lands back-to-back.
    task automatic do_op(input int d, input bit s, input logic [16:0] a,
                         input logic [16:0] b, input bit c, input bit hold);
        int g;
        start_i[d] = 1'b1;
        sub_i[d]   = s;
        x_i[d]     = a;
        y_i[d]     = b;
        ci_i[d]    = c;
        exp_q.push_back(model(d, s, a, b, c));
        @(negedge clk);
        if (!hold) start_i[d] = 1'b0;
        g = 0;
        while (busy_o[d] && g < 60) begin
            if (hold) begin
                x_i[d]   = 17'($urandom);
                y_i[d]   = 17'($urandom);
                sub_i[d] = 1'($urandom);
                ci_i[d]  = 1'($urandom);
            end
            @(negedge clk);
            g++;
        end
        start_i[d] = 1'b0;
        check($sformatf("done_timeout[%0d]", d), 32'(g < 60), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            start_i[d] = 1'b0;
            sub_i[d]   = 1'b0;
            x_i[d]     = '0;
            y_i[d]     = '0;
            ci_i[d]    = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_busy[%0d]", d), 32'(busy_o[d]), 32'd0);
            check($sformatf("rst_done[%0d]", d), 32'(done_o[d]), 32'd0);
            check($sformatf("rst_z[%0d]", d),    32'(get_z(d)),  32'd0);
            check($sformatf("rst_co[%0d]", d),   32'(co_o[d]),   32'd0);
            check($sformatf("rst_ov[%0d]", d),   32'(ov_o[d]),   32'd0);
        end

        // Directed cases on the 16/4 build.
        do_op(0, 1'b0, 17'h07FFF, 17'h00001, 1'b0, 1'b0);
        idle(2);
        do_op(0, 1'b0, 17'h0FFFF, 17'h00001, 1'b0, 1'b0);
        do_op(0, 1'b0, 17'h01234, 17'h01111, 1'b1, 1'b0);
        idle(1);
        do_op(0, 1'b1, 17'h00005, 17'h00007, 1'b0, 1'b0);
        idle(1);
        do_op(0, 1'b1, 17'h08000, 17'h00001, 1'b0, 1'b0);
        do_op(0, 1'b0, 17'h00100, 17'h00200, 1'b0, 1'b1);
        do_op(0, 1'b0, 17'h00002, 17'h00003, 1'b0, 1'b0);
        idle(3);

        // Reset in the second RUN cycle: aborts with no done.
        start_i[0] = 1'b1;
        x_i[0]     = 17'h01111;
        y_i[0]     = 17'h02222;
        @(negedge clk);
        start_i[0] = 1'b0;
        @(negedge clk);
        check("abort_in_run", 32'(busy_o[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy_o[0]), 32'd0);
        check("abort_done", 32'(done_o[0]), 32'd0);
        check("abort_z",    32'(z0),        32'd0);
        check("abort_co",   32'(co_o[0]),   32'd0);
        check("abort_ov",   32'(ov_o[0]),   32'd0);
        rst = 1'b0;
        idle(12);

        // Random traffic on 16/4 with random gaps and held start.
        for (int i = 0; i < 150; i++) begin
            do_op(0, 1'($urandom), 17'($urandom), 17'($urandom), 1'($urandom),
                  $urandom_range(0, 3) == 0);
            idle($urandom_range(0, 2));
        end

        // N=1 build.
        do_op(1, 1'b0, 17'h07FFF, 17'h00001, 1'b0, 1'b0);
        idle(1);
        for (int i = 0; i < 20; i++) begin
            do_op(1, 1'($urandom), 17'($urandom), 17'($urandom), 1'($urandom),
                  $urandom_range(0, 3) == 0);
            idle($urandom_range(0, 2));
        end

        // N=17 build.
        do_op(2, 1'b0, 17'h0FFFF, 17'h00001, 1'b0, 1'b0);
        idle(1);
        for (int i = 0; i < 20; i++) begin
            do_op(2, 1'($urandom), 17'($urandom), 17'($urandom), 1'($urandom),
                  $urandom_range(0, 3) == 0);
            idle($urandom_range(0, 2));
        end

        idle(5);
        check("results_outstanding", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
